// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package if_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
    localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } buf_entry_t;

    localparam int BUF_ENTRY_W = $bits(buf_entry_t);

endpackage

// File: rtl/if_fetch_ctrl_fifo.sv
// Synchronous FIFO with flush and occupancy count; a push in the flush cycle
// lands as the sole entry of the emptied queue.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    assign mem_we  = flush ? push : do_push;
    assign mem_wa  = flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? ptr_inc('0) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset: count/pointers define which words are live.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= din;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Pre-IF/IF fetch controller: issues sequential SRAM-like instruction reads,
// discards responses of flushed streams and buffers {pc, inst, adel} for ID.
module if_fetch_ctrl
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [3:0]  inst_wstrb,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adel,
    input  logic        out_ready
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   occupancy;
    logic          credit;
    logic          fetch_misaligned;
    logic          redir_misaligned;
    logic          addr_hs;
    logic          data_hs;
    logic          data_keep;
    logic          halt_push;

    logic          pcq_push;
    logic [31:0]   pcq_dout;
    logic          pcq_empty;
    logic          pcq_full;
    logic [CW-1:0] pcq_count;

    logic          buf_push;
    logic          buf_pop;
    buf_entry_t    buf_din;
    buf_entry_t    buf_dout;
    logic          buf_empty;
    logic          buf_full;

    // In-flight plus buffered fetches never exceed the buffer size, so every
    // accepted request is guaranteed a slot when its data returns.
    assign occupancy        = {1'b0, inflight} + {1'b0, buf_count};
    assign credit           = occupancy < (CW+1)'(BUF_DEPTH);
    assign fetch_misaligned = (fetch_pc[1:0] != 2'b00);
    assign redir_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

    assign inst_req   = (state == S_FETCH) & credit & ~fetch_misaligned;
    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_addr  = fetch_pc;
    assign inst_wstrb = 4'h0;
    assign inst_wdata = 32'h0;

    assign addr_hs   = inst_req & inst_addr_ok;
    assign data_hs   = inst_data_ok & (inflight != '0);
    assign data_keep = data_hs & (drop_cnt == '0) & ~redirect_valid;
    assign halt_push = (state == S_FETCH) & credit & fetch_misaligned &
                       ~redirect_valid & ~data_keep;

    assign inflight_nxt = inflight + CW'(addr_hs) - CW'(data_hs);

    assign pcq_push = addr_hs & ~redirect_valid;
    assign buf_pop  = out_valid & out_ready & ~redirect_valid;

    always_comb begin
        buf_push = 1'b0;
        buf_din  = '0;
        if (redir_misaligned) begin
            buf_push     = 1'b1;
            buf_din.pc   = redirect_pc;
            buf_din.adel = 1'b1;
        end else if (data_keep) begin
            buf_push     = 1'b1;
            buf_din.pc   = pcq_dout;
            buf_din.inst = inst_rdata;
        end else if (halt_push) begin
            buf_push     = 1'b1;
            buf_din.pc   = fetch_pc;
            buf_din.adel = 1'b1;
        end
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(BUF_DEPTH)) u_pc_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (pcq_push),
        .din   (fetch_pc),
        .pop   (data_keep),
        .dout  (pcq_dout),
        .empty (pcq_empty),
        .full  (pcq_full),
        .count (pcq_count)
    );

    fetch_fifo #(.WIDTH(BUF_ENTRY_W), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (buf_push),
        .din   (buf_din),
        .pop   (buf_pop),
        .dout  (buf_dout),
        .empty (buf_empty),
        .full  (buf_full),
        .count (buf_count)
    );

    assign out_valid = ~buf_empty;
    assign out_pc    = buf_dout.pc;
    assign out_inst  = buf_dout.inst;
    assign out_adel  = out_valid & buf_dout.adel;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: if (halt_push) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_RESET;
        endcase
        if (redirect_valid)
            state_nxt = redir_misaligned ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RESET;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                // Everything still outstanding belongs to the old stream.
                fetch_pc <= redirect_pc;
                drop_cnt <= inflight_nxt;
            end else begin
                if (addr_hs) fetch_pc <= fetch_pc + 32'd4;
                if (data_hs && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inst_data_ok && inflight == '0));
            assert (!(data_keep && pcq_empty));
        end
    end

    logic unused_sigs;
    assign unused_sigs = &{1'b0, pcq_full, pcq_count, buf_full};

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a small in-order bridge model
// (1-cycle addr_ok, data two cycles after acceptance).
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_adel;
    logic [31:0] out_pc, out_inst;
    logic        out_ready = 1'b0;

    int ncmp = 0, nfail = 0;
    int cyc = 0, n_acc = 0;
    bit auto_en = 1'b0, poison = 1'b0;
    logic [31:0] q_data[$];
    int          q_due[$];
    logic [31:0] dpc[$], dinst[$];
    logic        dadel[$];

    if_fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_adel(out_adel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5a5a5a5a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive bridge + record ID handshake, edge, then bridge bookkeeping.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_a;
        inst_addr_ok = auto_en & inst_req;
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
        if (q_due.size() > 0 && q_due[0] == cyc + 1) begin
            inst_data_ok = 1'b1;
            inst_rdata   = q_data[0];
        end
        if (out_valid && out_ready && !redirect_valid) begin
            dpc.push_back(out_pc);
            dinst.push_back(out_inst);
            dadel.push_back(out_adel);
        end
        acc   = inst_addr_ok;
        acc_a = inst_addr;
        @(posedge clk);
        cyc++;
        if (inst_data_ok) begin
            void'(q_data.pop_front());
            void'(q_due.pop_front());
        end
        if (acc) begin
            q_data.push_back(poison ? 32'hdeadbeef : mem_word(acc_a));
            q_due.push_back(cyc + 2);
            n_acc++;
        end
        if (reset) begin
            q_data.delete();
            q_due.delete();
        end
        #1;
    endtask

    task automatic run_until_deliv(input int n, input string tag);
        int k = 0;
        while (dpc.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk(tag, 32'(dpc.size() >= n), 32'd1);
    endtask

    task automatic run_until_idle(input string tag);
        int k = 0;
        while ((q_due.size() != 0 || out_valid) && k < 40) begin
            tick();
            k++;
        end
        chk(tag, 32'(q_due.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        int n0, n1, n2, n3, a0;
        bit beef;

        // Reset state
        tick();
        tick();
        chk("rst_req",   32'(inst_req),  32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_adel",  32'(out_adel),  32'd0);
        chk("rst_addr",  inst_addr,      32'hbfc00000);
        dpc.delete(); dinst.delete(); dadel.delete();

        // Sequential fetch with cycle-exact first transaction
        reset = 1'b0; auto_en = 1'b1; out_ready = 1'b1;
        tick();
        chk("first_req",  32'(inst_req), 32'd1);
        chk("first_addr", inst_addr,     32'hbfc00000);
        tick();
        chk("addr_inc",   inst_addr,      32'hbfc00004);
        chk("early_valid",32'(out_valid), 32'd0);
        tick();
        chk("credit_stop",32'(inst_req),  32'd0);
        tick();
        chk("lat_valid",  32'(out_valid), 32'd1);
        chk("lat_pc",     out_pc,         32'hbfc00000);
        chk("lat_inst",   out_inst,       32'he59a5a5a);
        run_until_deliv(3, "seq_deliv");
        chk("seq_pc1",   dpc[1],   32'hbfc00004);
        chk("seq_inst1", dinst[1], 32'he59a5a5e);
        chk("seq_pc2",   dpc[2],   32'hbfc00008);
        chk("seq_inst2", dinst[2], 32'he59a5a52);

        // Back-pressure: buffer fills, issue stops, then drains in order
        out_ready = 1'b0;
        a0 = n_acc;
        repeat (12) tick();
        chk("hold_req",   32'(inst_req),         32'd0);
        chk("hold_valid", 32'(out_valid),        32'd1);
        chk("hold_count", 32'(dut.buf_count),    32'd2);
        chk("hold_acc",   32'((n_acc - a0) <= 2), 32'd1);
        n0 = dpc.size();
        out_ready = 1'b1;
        run_until_deliv(n0 + 4, "release_deliv");
        for (int i = 0; i < dpc.size(); i++)
            chk("order_pc", dpc[i], 32'hbfc00000 + 32'(4 * i));

        // Redirect with one read outstanding
        auto_en = 1'b0;
        run_until_idle("idle1");
        poison = 1'b1; auto_en = 1'b1;
        tick();
        auto_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00100;
        tick();
        redirect_valid = 1'b0; poison = 1'b0; auto_en = 1'b1;
        chk("r1_drop",     32'(dut.drop_cnt), 32'd1);
        chk("r1_inflight", 32'(dut.inflight), 32'd1);
        n1 = dpc.size();
        run_until_deliv(n1 + 2, "r1_deliv");
        chk("r1_pc0",   dpc[n1],     32'hbfc00100);
        chk("r1_inst0", dinst[n1],   32'he59a5b5a);
        chk("r1_pc1",   dpc[n1 + 1], 32'hbfc00104);

        // Redirect coinciding with data_ok and addr_ok
        auto_en = 1'b0;
        run_until_idle("idle2");
        poison = 1'b1; auto_en = 1'b1;
        tick();
        auto_en = 1'b0;
        tick();
        chk("r2_pre_req", 32'(inst_req), 32'd1);
        auto_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hbfc00200;
        tick();
        redirect_valid = 1'b0; poison = 1'b0;
        chk("r2_drop",     32'(dut.drop_cnt), 32'd1);
        chk("r2_inflight", 32'(dut.inflight), 32'd1);
        n2 = dpc.size();
        run_until_deliv(n2 + 1, "r2_deliv");
        chk("r2_pc",   dpc[n2],   32'hbfc00200);
        chk("r2_inst", dinst[n2], 32'he59a585a);

        // Misaligned redirect: adel entry, fetch halts until a new redirect
        out_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00102;
        tick();
        redirect_valid = 1'b0;
        chk("adel_req",   32'(inst_req),  32'd0);
        chk("adel_valid", 32'(out_valid), 32'd1);
        chk("adel_flag",  32'(out_adel),  32'd1);
        chk("adel_pc",    out_pc,         32'hbfc00102);
        chk("adel_inst",  out_inst,       32'h0);
        a0 = n_acc;
        repeat (6) tick();
        chk("halt_req",  32'(inst_req),   32'd0);
        chk("halt_acc",  32'(n_acc - a0), 32'd0);
        chk("halt_pc",   out_pc,          32'hbfc00102);
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00380;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        n3 = dpc.size();
        run_until_deliv(n3 + 1, "r3_deliv");
        chk("r3_pc",   dpc[n3],        32'hbfc00380);
        chk("r3_inst", dinst[n3],      32'he59a59da);
        chk("r3_adel", 32'(dadel[n3]), 32'd0);

        beef = 1'b0;
        foreach (dinst[i]) if (dinst[i] == 32'hdeadbeef) beef = 1'b1;
        chk("no_stale_data", 32'(beef), 32'd0);

        // Reset while entries are buffered
        out_ready = 1'b0;
        repeat (10) tick();
        chk("pre_rst_valid", 32'(out_valid),      32'd1);
        chk("pre_rst_count", 32'(dut.buf_count),  32'd2);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_req",   32'(inst_req),  32'd0);
        chk("mid_rst_addr",  inst_addr,      32'hbfc00000);
        reset = 1'b0;
        tick();
        chk("post_rst_req",  32'(inst_req),  32'd1);
        chk("post_rst_addr", inst_addr,      32'hbfc00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
